// File: rtl/dot_product_engine_if.sv
// Write/read/status bundle for dot_product_engine.
// master = register write path and display logic, slave = the engine.
interface dot_product_engine_if #(
  parameter int unsigned W    = 8,
  parameter int unsigned N    = 4,
  parameter int unsigned ACCW = 16
);
  localparam int unsigned IW = ($clog2(N) > 0) ? $clog2(N) : 1;

  logic          wr_en;
  logic          wr_vec;
  logic [IW-1:0] wr_idx;
  logic [W-1:0]  wr_data;
  logic          clr_vec;
  logic          start;
  logic          rd_vec;
  logic [IW-1:0] rd_idx;
  logic [W-1:0]  rd_data;
  logic          all_written;
  logic          busy;
  logic          done;
  logic [ACCW-1:0] result;
  logic          oflo;

  modport master (
    output wr_en, wr_vec, wr_idx, wr_data, clr_vec, start, rd_vec, rd_idx,
    input  rd_data, all_written, busy, done, result, oflo
  );

  modport slave (
    input  wr_en, wr_vec, wr_idx, wr_data, clr_vec, start, rd_vec, rd_idx,
    output rd_data, all_written, busy, done, result, oflo
  );
endinterface

// File: rtl/dot_product_engine.sv
// Serial dot-product engine: two N x W-bit vectors, one MAC per cycle into an
// ACCW-bit accumulator with optional saturation; result/oflo held until next run.
module dot_product_engine #(
  parameter int unsigned W      = 8,
  parameter int unsigned N      = 4,
  parameter int unsigned ACCW   = 16,
  parameter bit          SIGNED = 1'b0,
  parameter bit          SAT    = 1'b0,
  parameter bit          AUTO   = 1'b1
) (
  input logic                 clk,
  input logic                 rst,
  dot_product_engine_if.slave bus
);
  localparam int unsigned IW = ($clog2(N) > 0) ? $clog2(N) : 1;

  typedef enum logic [1:0] {S_IDLE, S_CLEAR, S_RUN, S_DONE} state_e;
  state_e state_q, state_d;

  logic [W-1:0]    a_q [N];
  logic [W-1:0]    a_d [N];
  logic [W-1:0]    b_q [N];
  logic [W-1:0]    b_d [N];
  logic [N-1:0]    wa_q, wa_d, wb_q, wb_d;
  logic            dirty_q, dirty_d;
  logic [IW-1:0]   idx_q, idx_d;
  logic [ACCW-1:0] acc_q, acc_d;
  logic            ovf_q, ovf_d;
  logic [ACCW-1:0] result_q, result_d;
  logic            oflo_q, oflo_d;

  logic            all_written;
  logic            trigger;
  logic            last_term;

  logic [W-1:0]           op_a, op_b;
  logic [2*W-1:0]         prod_u;
  logic signed [2*W-1:0]  prod_s;
  logic [ACCW-1:0]        term;
  logic [ACCW:0]          sum_w;
  logic [ACCW-1:0]        sum;
  logic [ACCW-1:0]        sat_val;
  logic                   ovf_term;
  logic [ACCW-1:0]        mac;

  assign all_written = (&wa_q) & (&wb_q);
  assign trigger     = all_written && ((AUTO && dirty_q) || bus.start);
  assign last_term   = (idx_q == IW'(N - 1));

  // Vector storage; clear has priority over a same-cycle write.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    wa_d    = wa_q;
    wb_d    = wb_q;
    dirty_d = dirty_q;
    if (state_q == S_CLEAR) dirty_d = 1'b0;
    if (bus.clr_vec) begin
      a_d     = '{default: '0};
      b_d     = '{default: '0};
      wa_d    = '0;
      wb_d    = '0;
      dirty_d = 1'b0;
    end else if (bus.wr_en) begin
      if (bus.wr_vec) begin
        b_d[bus.wr_idx]  = bus.wr_data;
        wb_d[bus.wr_idx] = 1'b1;
      end else begin
        a_d[bus.wr_idx]  = bus.wr_data;
        wa_d[bus.wr_idx] = 1'b1;
      end
      dirty_d = 1'b1;
    end
  end

  // One multiply-accumulate term, reading the arrays live at idx_q.
  always_comb begin
    op_a   = a_q[idx_q];
    op_b   = b_q[idx_q];
    prod_u = {{W{1'b0}}, op_a} * {{W{1'b0}}, op_b};
    prod_s = $signed({{W{op_a[W-1]}}, op_a}) * $signed({{W{op_b[W-1]}}, op_b});
    term   = SIGNED ? ACCW'(prod_s) : ACCW'(prod_u);
    sum_w  = {1'b0, acc_q} + {1'b0, term};
    sum    = sum_w[ACCW-1:0];
    if (SIGNED) begin
      ovf_term = (acc_q[ACCW-1] == term[ACCW-1]) && (sum[ACCW-1] != acc_q[ACCW-1]);
      sat_val  = {acc_q[ACCW-1], {(ACCW-1){~acc_q[ACCW-1]}}};
    end else begin
      ovf_term = sum_w[ACCW];
      sat_val  = '1;
    end
    mac = (SAT && ovf_term) ? sat_val : sum;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (trigger) state_d = S_CLEAR;
      S_CLEAR: state_d = S_RUN;
      S_RUN:   if (last_term) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.clr_vec) state_d = S_IDLE;
  end

  always_comb begin
    acc_d    = acc_q;
    ovf_d    = ovf_q;
    idx_d    = idx_q;
    result_d = result_q;
    oflo_d   = oflo_q;
    case (state_q)
      S_CLEAR: begin
        acc_d = '0;
        ovf_d = 1'b0;
        idx_d = '0;
      end
      S_RUN: begin
        acc_d = mac;
        ovf_d = ovf_q | ovf_term;
        idx_d = idx_q + 1'b1;
        if (last_term && !bus.clr_vec) begin
          result_d = mac;
          oflo_d   = ovf_q | ovf_term;
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    bus.busy        = (state_q == S_CLEAR) || (state_q == S_RUN);
    bus.done        = (state_q == S_DONE);
    bus.all_written = all_written;
    bus.result      = result_q;
    bus.oflo        = oflo_q;
    bus.rd_data     = bus.rd_vec ? b_q[bus.rd_idx] : a_q[bus.rd_idx];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      a_q      <= '{default: '0};
      b_q      <= '{default: '0};
      wa_q     <= '0;
      wb_q     <= '0;
      dirty_q  <= 1'b0;
      idx_q    <= '0;
      acc_q    <= '0;
      ovf_q    <= 1'b0;
      result_q <= '0;
      oflo_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      wa_q     <= wa_d;
      wb_q     <= wb_d;
      dirty_q  <= dirty_d;
      idx_q    <= idx_d;
      acc_q    <= acc_d;
      ovf_q    <= ovf_d;
      result_q <= result_d;
      oflo_q   <= oflo_d;
    end
  end
endmodule

// File: tb/tb_dot_product_engine.sv
// Bench for dot_product_engine: five instances (unsigned/signed x wrap/sat with AUTO,
// plus a manual-start unsigned one) share one write stream and are checked against a model.
module tb_dot_product_engine;
  localparam int unsigned W = 8, N = 4, ACCW = 16, NG = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        wr_en, wr_vec, clr_vec, start_m, rd_vec;
  logic [1:0]  wr_idx, rd_idx;
  logic [7:0]  wr_data;

  logic        busy_a [NG];
  logic        done_a [NG];
  logic        allw_a [NG];
  logic        oflo_a [NG];
  logic [15:0] result_a [NG];
  logic [7:0]  rd_a [NG];

  int vectors = 0;
  int errors  = 0;

  logic [7:0]  ma [N];
  logic [7:0]  mb [N];
  logic [15:0] exp_res [NG];
  logic        exp_ofl [NG];

  always #5 clk = ~clk;

  // Instance g: 0 unsigned wrap, 1 unsigned sat, 2 signed wrap, 3 signed sat, 4 manual.
  for (genvar g = 0; g < NG; g++) begin : gd
    dot_product_engine_if #(.W(W), .N(N), .ACCW(ACCW)) ifc ();
    dot_product_engine #(
      .W(W), .N(N), .ACCW(ACCW),
      .SIGNED(g == 2 || g == 3), .SAT(g == 1 || g == 3), .AUTO(g != 4)
    ) dut (
      .clk(clk),
      .rst(rst),
      .bus(ifc.slave)
    );
    assign ifc.wr_en   = wr_en;
    assign ifc.wr_vec  = wr_vec;
    assign ifc.wr_idx  = wr_idx;
    assign ifc.wr_data = wr_data;
    assign ifc.clr_vec = clr_vec;
    assign ifc.start   = (g == 4) ? start_m : 1'b0;
    assign ifc.rd_vec  = rd_vec;
    assign ifc.rd_idx  = rd_idx;
    assign busy_a[g]   = ifc.busy;
    assign done_a[g]   = ifc.done;
    assign allw_a[g]   = ifc.all_written;
    assign oflo_a[g]   = ifc.oflo;
    assign result_a[g] = ifc.result;
    assign rd_a[g]     = ifc.rd_data;
  end

  // Dot product by plain integer arithmetic, wrapped or clamped to the 16-bit range.
  function automatic logic [16:0] ref_dot(input bit sg, input bit sat);
    longint acc, lo, hi;
    logic   ov;
    logic [15:0] r;
    acc = 0;
    ov  = 1'b0;
    lo  = sg ? -32768 : 0;
    hi  = sg ? 32767 : 65535;
    for (int i = 0; i < N; i++) begin
      if (sg) acc += longint'($signed(ma[i])) * longint'($signed(mb[i]));
      else    acc += longint'(ma[i]) * longint'(mb[i]);
      if (acc > hi || acc < lo) begin
        ov = 1'b1;
        if (sat) acc = (acc > hi) ? hi : lo;
        else begin
          acc = acc & 64'hFFFF;
          if (sg && acc > 32767) acc -= 65536;
        end
      end
    end
    r = acc[15:0];
    return {ov, r};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      ma[i] = '0;
      mb[i] = '0;
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input bit v, input int idx, input logic [7:0] d);
    wr_en   = 1'b1;
    wr_vec  = v;
    wr_idx  = idx[1:0];
    wr_data = d;
    step();
    wr_en = 1'b0;
    if (v) mb[idx] = d;
    else   ma[idx] = d;
  endtask

  task automatic clr();
    clr_vec = 1'b1;
    step();
    clr_vec = 1'b0;
    model_clear();
  endtask

  task automatic load(input logic [31:0] av, input logic [31:0] bv);
    for (int i = 0; i < N; i++) wr(1'b0, i, av[8*i +: 8]);
    for (int i = 0; i < N; i++) wr(1'b1, i, bv[8*i +: 8]);
  endtask

  // Called right after the completing write: waits for done on the AUTO instances.
  task automatic run_auto(input string name, input bit midw);
    int lat, bcnt;
    logic [16:0] r;
    logic [15:0] er [4];
    logic        eo [4];
    for (int g = 0; g < 4; g++) begin
      r = ref_dot(g == 2 || g == 3, g == 1 || g == 3);
      er[g] = r[15:0];
      eo[g] = r[16];
    end
    lat  = 0;
    bcnt = 0;
    while (done_a[0] !== 1'b1 && lat < 4 * N) begin
      step();
      lat++;
      if (midw && lat == 3) begin
        wr_en = 1'b1; wr_vec = 1'b0; wr_idx = 2'd0; wr_data = 8'd9;
      end
      if (midw && lat == 4) begin
        wr_en = 1'b0;
        ma[0] = 8'd9;
      end
      if (busy_a[0] === 1'b1) bcnt++;
    end
    vectors++;
    if (done_a[0] !== 1'b1) begin
      errors++;
      $display("FAIL %s done_timeout: done=%b after %0d cycles, expected 1", name, done_a[0], lat);
    end
    vectors++;
    if (lat != N + 2) begin
      errors++;
      $display("FAIL %s latency: got %0d cycles, expected %0d", name, lat, N + 2);
    end
    vectors++;
    if (bcnt != N + 1) begin
      errors++;
      $display("FAIL %s busy_len: got %0d cycles, expected %0d", name, bcnt, N + 1);
    end
    for (int g = 0; g < 4; g++) begin
      vectors++;
      if (done_a[g] !== 1'b1 || busy_a[g] !== 1'b0 || result_a[g] !== er[g] || oflo_a[g] !== eo[g]) begin
        errors++;
        $display("FAIL %s g%0d result: done=%b busy=%b result=%h oflo=%b, expected done=1 busy=0 result=%h oflo=%b",
                 name, g, done_a[g], busy_a[g], result_a[g], oflo_a[g], er[g], eo[g]);
      end
      exp_res[g] = er[g];
      exp_ofl[g] = eo[g];
    end
    step();
    vectors++;
    if (done_a[0] !== 1'b0 || busy_a[0] !== 1'b0 || result_a[0] !== er[0]) begin
      errors++;
      $display("FAIL %s pulse_hold: done=%b busy=%b result=%h, expected done=0 busy=0 result=%h",
               name, done_a[0], busy_a[0], result_a[0], er[0]);
    end
  endtask

  task automatic run_manual(input string name);
    int lat;
    logic [16:0] r;
    r = ref_dot(1'b0, 1'b0);
    start_m = 1'b1;
    lat = 0;
    while (done_a[4] !== 1'b1 && lat < 4 * N) begin
      step();
      start_m = 1'b0;
      lat++;
    end
    vectors++;
    if (done_a[4] !== 1'b1 || lat != N + 2 || result_a[4] !== r[15:0] || oflo_a[4] !== r[16]) begin
      errors++;
      $display("FAIL %s manual: done=%b lat=%0d result=%h oflo=%b, expected done=1 lat=%0d result=%h oflo=%b",
               name, done_a[4], lat, result_a[4], oflo_a[4], N + 2, r[15:0], r[16]);
    end
    exp_res[4] = r[15:0];
    exp_ofl[4] = r[16];
    step();
    vectors++;
    if (done_a[4] !== 1'b0) begin
      errors++;
      $display("FAIL %s manual_pulse: done=%b, expected 0", name, done_a[4]);
    end
  endtask

  task automatic check_zeroed(input string name);
    for (int g = 0; g < NG; g++) begin
      vectors++;
      if (busy_a[g] !== 1'b0 || done_a[g] !== 1'b0 || result_a[g] !== 16'h0 ||
          oflo_a[g] !== 1'b0 || allw_a[g] !== 1'b0) begin
        errors++;
        $display("FAIL %s g%0d zero: busy=%b done=%b result=%h oflo=%b all_written=%b, expected all 0",
                 name, g, busy_a[g], done_a[g], result_a[g], oflo_a[g], allw_a[g]);
      end
    end
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < N; i++) begin
        rd_vec = v[0];
        rd_idx = i[1:0];
        #1;
        vectors++;
        if (rd_a[0] !== 8'h00) begin
          errors++;
          $display("FAIL %s rd_zero vec%0d[%0d]: got %h, expected 00", name, v, i, rd_a[0]);
        end
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #2;
    check_zeroed("reset");
    @(negedge clk);
    rst = 1'b0;
    step();
  endtask

  task automatic test_basic();
    load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
    vectors++;
    if (allw_a[0] !== 1'b1 || busy_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic all_written: all_written=%b busy=%b, expected 1 0", allw_a[0], busy_a[0]);
    end
    run_auto("basic", 1'b0);
    vectors++;
    if (result_a[0] !== 16'h0046 || oflo_a[0] !== 1'b0) begin
      errors++;
      $display("FAIL basic const: result=%h oflo=%b, expected 0046 0", result_a[0], oflo_a[0]);
    end
    vectors++;
    if (busy_a[4] !== 1'b0 || result_a[4] !== 16'h0) begin
      errors++;
      $display("FAIL basic manual_idle: busy=%b result=%h, expected 0 0000", busy_a[4], result_a[4]);
    end
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < N; i++) begin
        rd_vec = v[0];
        rd_idx = i[1:0];
        #1;
        vectors++;
        if (rd_a[0] !== (v == 0 ? ma[i] : mb[i])) begin
          errors++;
          $display("FAIL basic rd vec%0d[%0d]: got %h, expected %h", v, i, rd_a[0], (v == 0 ? ma[i] : mb[i]));
        end
      end
    end
    run_manual("basic");
  endtask

  task automatic test_signed();
    clr();
    load({8'h04, 8'hFD, 8'h02, 8'hFF}, {8'd8, 8'd7, 8'd6, 8'd5});
    run_auto("signed", 1'b0);
    vectors++;
    if (result_a[2] !== 16'h0012 || oflo_a[2] !== 1'b0) begin
      errors++;
      $display("FAIL signed const: result=%h oflo=%b, expected 0012 0", result_a[2], oflo_a[2]);
    end
  endtask

  task automatic test_overflow();
    clr();
    load(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    run_auto("ovf_ff", 1'b0);
    vectors++;
    if (result_a[0] !== 16'hF804 || oflo_a[0] !== 1'b1 || result_a[1] !== 16'hFFFF || oflo_a[1] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_ff const: wrap=%h/%b sat=%h/%b, expected F804/1 FFFF/1",
               result_a[0], oflo_a[0], result_a[1], oflo_a[1]);
    end
    clr();
    load(32'h8080_8080, 32'h8080_8080);
    run_auto("ovf_80", 1'b0);
    vectors++;
    if (result_a[2] !== 16'h0000 || oflo_a[2] !== 1'b1 || result_a[3] !== 16'h7FFF || oflo_a[3] !== 1'b1) begin
      errors++;
      $display("FAIL ovf_80 const: wrap=%h/%b sat=%h/%b, expected 0000/1 7FFF/1",
               result_a[2], oflo_a[2], result_a[3], oflo_a[3]);
    end
  endtask

  task automatic test_random();
    logic [31:0] av, bv;
    logic [7:0]  d;
    for (int it = 0; it < 8; it++) begin
      for (int i = 0; i < 2 * N; i++) begin
        case ($urandom_range(0, 7))
          0:       d = 8'hFF;
          1:       d = 8'h80;
          2:       d = 8'h7F;
          default: d = 8'($urandom_range(0, 255));
        endcase
        if (i < N) av[8*i +: 8] = d;
        else       bv[8*(i-N) +: 8] = d;
      end
      clr();
      load(av, bv);
      run_auto("random", 1'b0);
      run_manual("random");
    end
  endtask

  task automatic test_back_to_back();
    clr();
    load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
    run_auto("b2b_first", 1'b1);
    vectors++;
    if (result_a[0] !== 16'h0046) begin
      errors++;
      $display("FAIL b2b_first const: result=%h, expected 0046", result_a[0]);
    end
    run_auto("b2b_second", 1'b0);
  endtask

  task automatic test_clear_midrun();
    clr();
    load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
    step();
    step();
    step();
    clr();
    for (int g = 0; g < NG; g++) begin
      vectors++;
      if (busy_a[g] !== 1'b0 || allw_a[g] !== 1'b0) begin
        errors++;
        $display("FAIL clear g%0d: busy=%b all_written=%b, expected 0 0", g, busy_a[g], allw_a[g]);
      end
    end
    for (int v = 0; v < 2; v++) begin
      for (int i = 0; i < N; i++) begin
        rd_vec = v[0];
        rd_idx = i[1:0];
        #1;
        vectors++;
        if (rd_a[0] !== 8'h00) begin
          errors++;
          $display("FAIL clear rd vec%0d[%0d]: got %h, expected 00", v, i, rd_a[0]);
        end
      end
    end
    for (int c = 0; c < 8; c++) begin
      step();
      vectors++;
      if (done_a[0] !== 1'b0 || busy_a[0] !== 1'b0) begin
        errors++;
        $display("FAIL clear quiet: done=%b busy=%b, expected 0 0", done_a[0], busy_a[0]);
      end
    end
    for (int g = 0; g < NG; g++) begin
      vectors++;
      if (result_a[g] !== exp_res[g] || oflo_a[g] !== exp_ofl[g]) begin
        errors++;
        $display("FAIL clear hold g%0d: result=%h oflo=%b, expected %h %b",
                 g, result_a[g], oflo_a[g], exp_res[g], exp_ofl[g]);
      end
    end
  endtask

  task automatic test_async_reset();
    clr();
    load({8'd4, 8'd3, 8'd2, 8'd1}, {8'd8, 8'd7, 8'd6, 8'd5});
    step();
    step();
    step();
    #3;
    rst = 1'b1;
    #2;
    check_zeroed("async_rst");
    model_clear();
    for (int g = 0; g < NG; g++) begin
      exp_res[g] = '0;
      exp_ofl[g] = 1'b0;
    end
    #1;
    rst = 1'b0;
    step();
    for (int i = 0; i < N; i++) wr(1'b0, i, 8'(i + 3));
    start_m = 1'b1;
    step();
    start_m = 1'b0;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if (busy_a[4] !== 1'b0 || allw_a[4] !== 1'b0) begin
        errors++;
        $display("FAIL no_start busy=%b all_written=%b, expected 0 0", busy_a[4], allw_a[4]);
      end
      step();
    end
  endtask

  initial begin
    wr_en = 1'b0; wr_vec = 1'b0; wr_idx = '0; wr_data = '0;
    clr_vec = 1'b0; start_m = 1'b0; rd_vec = 1'b0; rd_idx = '0;
    model_clear();
    for (int g = 0; g < NG; g++) begin
      exp_res[g] = '0;
      exp_ofl[g] = 1'b0;
    end
    test_reset();
    test_basic();
    test_signed();
    test_overflow();
    test_random();
    test_back_to_back();
    test_clear_midrun();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end
endmodule
